// File: rtl/cpm_sequencer_if.sv
// CPM sequencer pin bundle: power-management side (START/results)
// and CPM macro side (scan chain, launch/capture clocks, TDC word).
interface cpm_sequencer_if;
    logic        START;
    logic [1:4]  CFG_S;
    logic [1:16] CPM_OUT;
    logic        SC_DIN;
    logic        SC_CLK;
    logic        SC_LEN;
    logic        CPL_CLK;
    logic        TDC_CLK;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  AVG_CODE;
    logic [4:0]  MIN_CODE;
    logic [4:0]  MAX_CODE;
    logic        SAT_LO;
    logic        SAT_HI;
    logic        BUBBLE;

    modport master (
        output START,
        output CFG_S,
        output CPM_OUT,
        input  SC_DIN,
        input  SC_CLK,
        input  SC_LEN,
        input  CPL_CLK,
        input  TDC_CLK,
        input  BUSY,
        input  DONE,
        input  AVG_CODE,
        input  MIN_CODE,
        input  MAX_CODE,
        input  SAT_LO,
        input  SAT_HI,
        input  BUBBLE
    );

    modport slave (
        input  START,
        input  CFG_S,
        input  CPM_OUT,
        output SC_DIN,
        output SC_CLK,
        output SC_LEN,
        output CPL_CLK,
        output TDC_CLK,
        output BUSY,
        output DONE,
        output AVG_CODE,
        output MIN_CODE,
        output MAX_CODE,
        output SAT_LO,
        output SAT_HI,
        output BUBBLE
    );
endinterface

// File: rtl/cpm_sequencer.sv
// Critical Path Monitor burst sequencer: scan-loads the path select,
// runs NUM_MEAS launch/capture cycles and reports avg/min/max codes.
module cpm_sequencer #(
    parameter int LOG2_MEAS = 2,
    parameter int CAP_DLY   = 4,
    parameter int SETTLE    = 8
) (
    input logic            CLK,
    input logic            RST,
    cpm_sequencer_if.slave bus
);

    localparam int NUM_MEAS = 1 << LOG2_MEAS;
    localparam int SW       = 5 + LOG2_MEAS;
    localparam int MW       = LOG2_MEAS + 1;
    localparam int CMAX_A   = (CAP_DLY > 8) ? CAP_DLY : 8;
    localparam int CMAX     = (SETTLE > CMAX_A) ? SETTLE : CMAX_A;
    localparam int CW       = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [MW-1:0]   meas_q;
    logic [MW-1:0]   meas_d;
    logic [1:4]      cfg_q;
    logic [1:4]      cfg_d;

    logic [SW-1:0]   sum_q;
    logic [4:0]      min_q;
    logic [4:0]      max_q;
    logic            lo_q;
    logic            hi_q;
    logic            bub_q;

    logic [4:0]      code;
    logic            bub_c;
    logic            seen0;

    logic            sc_din_d;
    logic            sc_clk_d;
    logic            sc_len_d;
    logic            cpl_d;
    logic            tdc_d;
    logic            busy_d;
    logic            done_d;

    logic            sc_din_q;
    logic            sc_clk_q;
    logic            sc_len_q;
    logic            cpl_q;
    logic            tdc_q;
    logic            busy_q;
    logic            done_q;
    logic [4:0]      avg_o;
    logic [4:0]      min_o;
    logic [4:0]      max_o;
    logic            sat_lo_o;
    logic            sat_hi_o;
    logic            bubble_o;

    // Thermometer decode: leading run of ones from bit 1, plus bubble detect.
    always_comb begin
        code  = 5'd0;
        bub_c = 1'b0;
        seen0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (bus.CPM_OUT[i]) begin
                if (seen0) begin
                    bub_c = 1'b1;
                end else begin
                    code = code + 5'd1;
                end
            end else begin
                seen0 = 1'b1;
            end
        end
    end

    // Sequencer state, cycle counter, measurement index and captured select.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            meas_q  <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            cfg_q   <= cfg_d;
        end
    end

    // Next state plus the pin values for the cycle being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        meas_d   = meas_q;
        cfg_d    = cfg_q;
        sc_din_d = 1'b0;
        sc_clk_d = 1'b0;
        sc_len_d = 1'b0;
        cpl_d    = 1'b0;
        tdc_d    = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    meas_d  = '0;
                    cfg_d   = bus.CFG_S;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(7)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_LAUNCH;
                cnt_d   = '0;
            end
            ST_LAUNCH: begin
                if (cnt_q == CW'(CAP_DLY - 1)) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d = '0;
                    if (meas_q == MW'(NUM_MEAS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LAUNCH;
                        meas_d  = meas_q + MW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_SHIFT: begin
                sc_clk_d = cnt_d[0];
                unique case (cnt_d[2:1])
                    2'd0: sc_din_d = cfg_d[4];
                    2'd1: sc_din_d = cfg_d[3];
                    2'd2: sc_din_d = cfg_d[2];
                    2'd3: sc_din_d = cfg_d[1];
                endcase
            end
            ST_LATCH: begin
                sc_len_d = 1'b1;
            end
            ST_LAUNCH: begin
                cpl_d = 1'b1;
            end
            ST_CAPTURE: begin
                cpl_d = 1'b1;
                tdc_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Fold each sampled TDC code into the running sum, min, max and flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q <= '0;
            min_q <= '0;
            max_q <= '0;
            lo_q  <= 1'b0;
            hi_q  <= 1'b0;
            bub_q <= 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            if (meas_q == '0) begin
                sum_q <= SW'(code);
                min_q <= code;
                max_q <= code;
                lo_q  <= (code == 5'd0);
                hi_q  <= (code == 5'd16);
                bub_q <= bub_c;
            end else begin
                sum_q <= sum_q + SW'(code);
                min_q <= (code < min_q) ? code : min_q;
                max_q <= (code > max_q) ? code : max_q;
                lo_q  <= lo_q | (code == 5'd0);
                hi_q  <= hi_q | (code == 5'd16);
                bub_q <= bub_q | bub_c;
            end
        end
    end

    // Registered pins; results refresh only on entry to the DONE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sc_din_q <= 1'b0;
            sc_clk_q <= 1'b0;
            sc_len_q <= 1'b0;
            cpl_q    <= 1'b0;
            tdc_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            avg_o    <= '0;
            min_o    <= '0;
            max_o    <= '0;
            sat_lo_o <= 1'b0;
            sat_hi_o <= 1'b0;
            bubble_o <= 1'b0;
        end else begin
            sc_din_q <= sc_din_d;
            sc_clk_q <= sc_clk_d;
            sc_len_q <= sc_len_d;
            cpl_q    <= cpl_d;
            tdc_q    <= tdc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (done_d) begin
                avg_o    <= 5'(sum_q >> LOG2_MEAS);
                min_o    <= min_q;
                max_o    <= max_q;
                sat_lo_o <= lo_q;
                sat_hi_o <= hi_q;
                bubble_o <= bub_q;
            end
        end
    end

    assign bus.SC_DIN   = sc_din_q;
    assign bus.SC_CLK   = sc_clk_q;
    assign bus.SC_LEN   = sc_len_q;
    assign bus.CPL_CLK  = cpl_q;
    assign bus.TDC_CLK  = tdc_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.AVG_CODE = avg_o;
    assign bus.MIN_CODE = min_o;
    assign bus.MAX_CODE = max_o;
    assign bus.SAT_LO   = sat_lo_o;
    assign bus.SAT_HI   = sat_hi_o;
    assign bus.BUBBLE   = bubble_o;

endmodule

// File: tb/tb_cpm_sequencer.sv
// Directed bench for cpm_sequencer: scan load, burst timing, decode,
// corner codes, back-to-back handshake and mid-burst reset.
module tb_cpm_sequencer;

    logic CLK;
    logic RST;

    cpm_sequencer_if bus ();

    cpm_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [80:0] tr_cpl_rise;
    logic [80:0] tr_tdc;
    logic [80:0] tr_sclen;
    logic [80:0] tr_sclk_rise;
    logic [80:0] tr_din;
    logic [80:0] tr_busy;
    logic [80:0] tr_done;
    int          done_cyc;
    logic [3:0]  din_seq;
    logic [1:4]  scan_s;
    logic [1:4]  scan_lat;
    logic [4:0]  pre_avg;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] therm(input int c);
        logic [15:0] w;
        w = 16'hFFFF;
        if (c == 0) return 16'h0000;
        return w << (16 - c);
    endfunction

    function automatic logic [80:0] mask4(input int a, input int b,
                                          input int c, input int d);
        logic [80:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    function automatic logic [80:0] span(input int lo, input int hi);
        logic [80:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [24:0] all_outs();
        return {bus.SC_DIN, bus.SC_CLK, bus.SC_LEN, bus.CPL_CLK,
                bus.TDC_CLK, bus.BUSY, bus.DONE, bus.AVG_CODE,
                bus.MIN_CODE, bus.MAX_CODE, bus.SAT_LO, bus.SAT_HI,
                bus.BUBBLE};
    endfunction

    // Runs one burst, tracing pins for cycles 1..70 and modelling the scan chain.
    task automatic burst(input logic [1:4] cfg, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] w3, input bit pulse);
        logic prev_clk;
        logic prev_cpl;
        logic [15:0] w;
        tr_cpl_rise  = '0;
        tr_tdc       = '0;
        tr_sclen     = '0;
        tr_sclk_rise = '0;
        tr_din       = '0;
        tr_busy      = '0;
        tr_done      = '0;
        done_cyc     = 0;
        din_seq      = '0;
        scan_s       = '0;
        scan_lat     = '0;
        prev_clk     = 1'b0;
        prev_cpl     = 1'b0;
        w            = w0;
        bus.CFG_S    = cfg;
        bus.START    = 1'b1;
        tick();
        bus.START    = 1'b0;
        bus.CFG_S    = ~cfg;
        for (int c = 1; c <= 70; c++) begin
            if (c == 1) pre_avg = bus.AVG_CODE;
            tr_cpl_rise[c]  = bus.CPL_CLK & ~prev_cpl;
            prev_cpl        = bus.CPL_CLK;
            tr_sclk_rise[c] = bus.SC_CLK & ~prev_clk;
            if (bus.SC_CLK && !prev_clk) begin
                din_seq = {din_seq[2:0], bus.SC_DIN};
                scan_s  = {bus.SC_DIN, scan_s[1:3]};
            end
            prev_clk    = bus.SC_CLK;
            if (bus.SC_LEN) scan_lat = scan_s;
            tr_tdc[c]   = bus.TDC_CLK;
            tr_sclen[c] = bus.SC_LEN;
            tr_din[c]   = bus.SC_DIN;
            tr_busy[c]  = bus.BUSY;
            tr_done[c]  = bus.DONE;
            if (bus.DONE && done_cyc == 0) done_cyc = c;
            if (c >= 10 && c < 66) begin
                case ((c - 10) / 14)
                    0:       w = w0;
                    1:       w = w1;
                    2:       w = w2;
                    default: w = w3;
                endcase
                bus.CPM_OUT = w;
            end
            bus.START = pulse && (c == 20 || c == 66);
            tick();
        end
        bus.START = 1'b0;
    endtask

    initial begin
        int ndone;
        int dpos0;
        int dpos1;
        logic b67;
        logic b68;

        RST         = 1'b1;
        bus.START   = 1'b0;
        bus.CFG_S   = 4'b0000;
        bus.CPM_OUT = 16'h0000;
        tick();
        tick();
        chk("reset_outs", all_outs(), 25'd0);
        RST = 1'b0;
        tick();
        chk("idle_busy", bus.BUSY, 1'b0);

        // Burst 1: scan load 1010, timing, clean codes 5,7,6,9.
        burst(4'b1010, therm(5), therm(7), therm(6), therm(9), 1'b0);
        chk("b1_done_cycle", done_cyc, 66);
        chk("b1_done_mask", tr_done, mask4(66, -1, -1, -1));
        chk("b1_busy_mask", tr_busy, span(1, 66));
        chk("b1_cpl_rise", tr_cpl_rise, mask4(10, 24, 38, 52));
        chk("b1_tdc_high", tr_tdc, mask4(14, 28, 42, 56));
        chk("b1_sclk_rise", tr_sclk_rise, mask4(2, 4, 6, 8));
        chk("b1_sclen", tr_sclen, mask4(9, -1, -1, -1));
        chk("b1_din_cycles", tr_din, mask4(3, 4, 7, 8));
        chk("b1_din_at_rise", din_seq, 4'b0101);
        chk("b1_scan_latched", scan_lat, 4'b1010);
        chk("b1_avg", bus.AVG_CODE, 5'd6);
        chk("b1_min", bus.MIN_CODE, 5'd5);
        chk("b1_max", bus.MAX_CODE, 5'd9);
        chk("b1_flags", {bus.SAT_LO, bus.SAT_HI, bus.BUBBLE}, 3'b000);

        // Burst 2: corner words, START pulses while busy and in DONE.
        burst(4'b0110, 16'hFFFF, 16'h0000, 16'hE800, 16'hC000, 1'b1);
        chk("b2_results_held", pre_avg, 5'd6);
        chk("b2_done_cycle", done_cyc, 66);
        chk("b2_no_rerun", tr_busy[70:67], 4'b0000);
        chk("b2_busy_after", bus.BUSY, 1'b0);
        chk("b2_scan_latched", scan_lat, 4'b0110);
        chk("b2_avg", bus.AVG_CODE, 5'd5);
        chk("b2_min", bus.MIN_CODE, 5'd0);
        chk("b2_max", bus.MAX_CODE, 5'd16);
        chk("b2_flags", {bus.SAT_LO, bus.SAT_HI, bus.BUBBLE}, 3'b111);

        // Burst 3: clean codes 1,2,3,4 clear the flags.
        burst(4'b0001, therm(1), therm(2), therm(3), therm(4), 1'b0);
        chk("b3_scan_latched", scan_lat, 4'b0001);
        chk("b3_avg", bus.AVG_CODE, 5'd2);
        chk("b3_min", bus.MIN_CODE, 5'd1);
        chk("b3_max", bus.MAX_CODE, 5'd4);
        chk("b3_flags", {bus.SAT_LO, bus.SAT_HI, bus.BUBBLE}, 3'b000);

        // Handshake: START held high gives back-to-back bursts.
        bus.CPM_OUT = therm(4);
        bus.CFG_S   = 4'b1111;
        bus.START   = 1'b1;
        tick();
        ndone = 0;
        dpos0 = 0;
        dpos1 = 0;
        b67   = 1'b1;
        b68   = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            if (bus.DONE) begin
                if (ndone == 0) dpos0 = c;
                if (ndone == 1) dpos1 = c;
                ndone++;
            end
            if (c == 67) b67 = bus.BUSY;
            if (c == 68) b68 = bus.BUSY;
            tick();
        end
        bus.START = 1'b0;
        chk("hs_done_count", ndone, 2);
        chk("hs_done_first", dpos0, 66);
        chk("hs_done_second", dpos1, 133);
        chk("hs_busy_gap", {b67, b68}, 2'b01);
        for (int i = 0; i < 100 && bus.BUSY; i++) tick();
        chk("hs_busy_timeout", bus.BUSY, 1'b0);
        chk("hs_avg", bus.AVG_CODE, 5'd4);

        // Reset in the middle of SHIFT clears everything at once.
        bus.CFG_S = 4'b1011;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_busy", bus.BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("rst_async_outs", all_outs(), 25'd0);
        #2;
        RST = 1'b0;
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.DONE || bus.BUSY) ndone++;
            tick();
        end
        chk("rst_no_activity", ndone, 0);
        chk("rst_idle_outs", all_outs(), 25'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
